alu_sequencer: RTL and testbench

Front-end controller for the shared N-bit ALU (add, sub, mul, div, exp, natural-exp). It arbitrates between two requesters round-robin, latches one operation, and issues it to the ALU with a start pulse. It then waits for the ALU's valid flag, under a timeout for the iterative units, and returns the 2N-bit result with a status code to the owning requester over a valid/ready handshake. One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU front-end sequencer: opcodes, response codes and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_MUL    = 3'd2,
      OP_DIV    = 3'd3,
      OP_EXP    = 3'd4,
      OP_NATEXP = 3'd5
   } opcode_e;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_OVF     = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   function automatic logic is_legal_op(input logic [2:0] sel);
      return sel <= 3'(OP_NATEXP);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       ptr
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After an accept the other requester gets priority; grant[0] set means requester 0 just won.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = grant[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/alu_sequencer.sv
// Front-end for the shared ALU: arbitrates two requesters, issues one operation at a time,
// waits for the result under a timeout and returns it over a per-requester valid/ready pair.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int N       = 32,
   parameter int TIMEOUT = 64
) (
   input  logic [0:0]     Clk,
   input  logic [0:0]     Rst_n,
   input  logic [1:0]     Req_Valid,
   output logic [1:0]     Req_Ready,
   input  logic [N-1:0]   Req_A0,
   input  logic [N-1:0]   Req_B0,
   input  logic [N-1:0]   Req_A1,
   input  logic [N-1:0]   Req_B1,
   input  logic [2:0]     Req_Sel0,
   input  logic [2:0]     Req_Sel1,
   output logic [1:0]     Rsp_Valid,
   input  logic [1:0]     Rsp_Ready,
   output logic [2*N-1:0] Rsp_Result,
   output logic [1:0]     Rsp_Err,
   output logic [N-1:0]   Alu_A,
   output logic [N-1:0]   Alu_B,
   output logic [2:0]     Alu_Sel,
   output logic [0:0]     Alu_Start,
   input  logic [2*N-1:0] Alu_Result,
   input  logic [0:0]     Alu_Valid,
   input  logic [0:0]     Alu_Ovf,
   output logic [1:0]     Dbg_State,
   output logic [0:0]     Dbg_Ptr
);

   // Handshakes: a request transfers when Req_Valid[i] & Req_Ready[i] at a rising edge; a response
   // transfers when Rsp_Valid[owner] & Rsp_Ready[owner]. Valid, once raised, holds its payload stable.

   localparam int CW = $clog2(TIMEOUT + 1);

   state_e         state_q,  state_d;
   logic [N-1:0]   a_q,      a_d;
   logic [N-1:0]   b_q,      b_d;
   logic [2:0]     sel_q,    sel_d;
   logic           owner_q,  owner_d;
   logic [2*N-1:0] result_q, result_d;
   logic [1:0]     err_q,    err_d;
   logic [CW-1:0]  cnt_q,    cnt_d;
   logic           rsp_valid_q, rsp_valid_d;

   logic [1:0] grant;
   logic       accept;
   logic [2:0] sel_in;

   rr_arbiter2 u_arb (
      .clk    (Clk),
      .rst_n  (Rst_n),
      .req    (Req_Valid),
      .accept (accept),
      .grant  (grant),
      .ptr    (Dbg_Ptr)
   );

   assign accept = (state_q == ST_IDLE) && (grant != 2'b00);
   assign sel_in = grant[1] ? Req_Sel1 : Req_Sel0;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      owner_d     = owner_q;
      result_d    = result_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = grant[1] ? Req_A1 : Req_A0;
               b_d     = grant[1] ? Req_B1 : Req_B0;
               sel_d   = sel_in;
               owner_d = grant[1];
               if (is_legal_op(sel_in)) begin
                  state_d = ST_ISSUE;
               end else begin
                  result_d = '0;
                  err_d    = ERR_ILLEGAL;
                  state_d  = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A result arriving in the timeout cycle still wins.
            if (Alu_Valid) begin
               result_d    = Alu_Result;
               err_d       = Alu_Ovf ? ERR_OVF : ERR_OK;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               result_d    = '0;
               err_d       = ERR_TIMEOUT;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            // Illegal opcodes enter with valid low and present one cycle later.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
            end else if (Rsp_Ready[owner_q]) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         owner_q     <= 1'b0;
         result_q    <= '0;
         err_q       <= ERR_OK;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         owner_q     <= owner_d;
         result_q    <= result_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign Req_Ready  = (state_q == ST_IDLE) ? grant : 2'b00;
   assign Rsp_Valid  = rsp_valid_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign Rsp_Result = result_q;
   assign Rsp_Err    = err_q;
   assign Alu_A      = a_q;
   assign Alu_B      = b_q;
   assign Alu_Sel    = sel_q;
   assign Alu_Start  = (state_q == ST_ISSUE);
   assign Dbg_State  = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: requester drivers, a behavioural ALU, and a response monitor
// that checks every response against an expected queue filled at accept time.
module tb_alu_sequencer;

   localparam int TMO = 8;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [2:0]  req_sel0, req_sel1;
   logic [1:0]  rsp_valid, rsp_ready;
   logic [63:0] rsp_result;
   logic [1:0]  rsp_err;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_sel;
   logic        alu_start;
   logic [63:0] alu_result;
   logic        alu_valid, alu_ovf;
   logic [1:0]  dbg_state;
   logic        dbg_ptr;

   alu_sequencer #(.N(32), .TIMEOUT(TMO)) dut (
      .Clk        (clk),
      .Rst_n      (rst_n),
      .Req_Valid  (req_valid),
      .Req_Ready  (req_ready),
      .Req_A0     (req_a0),
      .Req_B0     (req_b0),
      .Req_A1     (req_a1),
      .Req_B1     (req_b1),
      .Req_Sel0   (req_sel0),
      .Req_Sel1   (req_sel1),
      .Rsp_Valid  (rsp_valid),
      .Rsp_Ready  (rsp_ready),
      .Rsp_Result (rsp_result),
      .Rsp_Err    (rsp_err),
      .Alu_A      (alu_a),
      .Alu_B      (alu_b),
      .Alu_Sel    (alu_sel),
      .Alu_Start  (alu_start),
      .Alu_Result (alu_result),
      .Alu_Valid  (alu_valid),
      .Alu_Ovf    (alu_ovf),
      .Dbg_State  (dbg_state),
      .Dbg_Ptr    (dbg_ptr)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [66:0] exp_q[$];      // {owner, err, result}
   int          exp_cyc_q[$];  // cycle number at which Rsp_Valid must first appear
   int          n_total = 0;
   int          n_bad = 0;
   int          legal_cnt = 0;
   int          start_cnt = 0;
   logic        presenting = 1'b0;

   int   alu_delay = 1;         // WAIT cycle in which the ALU answers; 0 = never
   logic alu_ovf_cfg = 1'b0;
   int   stale_req = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] sel);
      case (sel)
         3'd0:    return {32'b0, a} + {32'b0, b};
         3'd1:    return {32'b0, a - b};
         3'd2:    return {32'b0, a} * {32'b0, b};
         3'd3:    return (b != 0) ? {32'b0, a / b} : '1;
         default: return 64'd0;
      endcase
   endfunction

   // ---------------- behavioural ALU ----------------
   initial begin
      int          d;
      int          stale_done;
      logic [63:0] res;
      stale_done = 0;
      alu_valid  = 1'b0;
      alu_result = '0;
      alu_ovf    = 1'b0;
      forever begin
         @(negedge clk);
         if (stale_req != stale_done) begin
            stale_done = stale_req;
            @(posedge clk); #1;
            alu_valid = 1'b1; alu_result = 64'hDEAD_BEEF; alu_ovf = 1'b1;
            @(posedge clk); #1;
            alu_valid = 1'b0; alu_ovf = 1'b0;
         end else if (alu_start && alu_delay > 0) begin
            d   = alu_delay;
            res = alu_model(alu_a, alu_b, alu_sel);
            repeat (d) @(posedge clk);
            #1;
            alu_valid = 1'b1; alu_result = res; alu_ovf = alu_ovf_cfg;
            @(posedge clk); #1;
            alu_valid = 1'b0; alu_ovf = 1'b0;
         end
      end
   end

   // ---------------- response monitor ----------------
   initial begin
      logic        prev_start;
      logic [1:0]  first_v, first_err;
      logic [63:0] first_res;
      logic [66:0] e;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            presenting = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (alu_start) begin
               start_cnt++;
               check("start_pulse_width", 160'(prev_start), 160'(1'b0));
            end
            prev_start = alu_start;
            if (rsp_valid == 2'b00 && presenting) begin
               n_total++; n_bad++;
               $display("FAIL rsp_dropped: valid fell before handshake at cycle %0d", cyc);
               presenting = 1'b0;
            end else if (rsp_valid != 2'b00) begin
               if (!presenting) begin
                  presenting = 1'b1;
                  first_v = rsp_valid; first_err = rsp_err; first_res = rsp_result;
                  if (exp_q.size() == 0) begin
                     n_total++; n_bad++;
                     $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", rsp_valid);
                  end else begin
                     check("rsp_latency", 160'(cyc), 160'(exp_cyc_q[0]));
                  end
               end else begin
                  check("rsp_hold", {rsp_valid, rsp_err, rsp_result}, {first_v, first_err, first_res});
               end
               check("req_ready_in_resp", 160'(req_ready), 160'(2'b00));
               if ((rsp_valid & rsp_ready) != 2'b00) begin
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     void'(exp_cyc_q.pop_front());
                     check("rsp_owner", 160'(rsp_valid), 160'(e[66] ? 2'b10 : 2'b01));
                     check("rsp_result", 160'(rsp_result), 160'(e[63:0]));
                     check("rsp_err", 160'(rsp_err), 160'(e[65:64]));
                  end
                  presenting = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_exp(input int idx, input logic [63:0] res, input logic [1:0] err,
                           input int lat, input logic [2:0] sel);
      exp_q.push_back({idx[0], err, res});
      exp_cyc_q.push_back(cyc + lat);
      if (sel < 3'd6) legal_cnt++;
   endtask

   task automatic load_port(input int idx, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] sel);
      if (idx == 0) begin
         req_a0 = a; req_b0 = b; req_sel0 = sel;
      end else begin
         req_a1 = a; req_b1 = b; req_sel1 = sel;
      end
   endtask

   task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input logic [63:0] res, input logic [1:0] err,
                       input int lat);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      load_port(idx, a, b, sel);
      req_valid[idx] = 1'b1;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (req_ready[idx]) begin
            push_exp(idx, res, err, lat, sel);
            got = 1'b1;
         end
      end
      if (!got) begin
         n_total++; n_bad++;
         $display("FAIL accept_timeout: requester %0d never accepted", idx);
      end
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !presenting;
      end
      if (!done) begin
         n_total++; n_bad++;
         $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   task automatic get_pair_op(input int g, input int i, output logic [31:0] a,
                              output logic [31:0] b, output logic [2:0] sel, output logic [63:0] res);
      if (g == 0) begin
         sel = 3'd1;
         if (i == 0) begin a = 32'd100; b = 32'd30; res = 64'd70; end
         else        begin a = 32'd9;   b = 32'd4;  res = 64'd5;  end
      end else begin
         sel = 3'd2;
         if (i == 0) begin a = 32'd6;    b = 32'd7;    res = 64'd42;      end
         else        begin a = 32'd1000; b = 32'd1000; res = 64'd1000000; end
      end
   endtask

   // Both requesters hold valid continuously; grants must alternate starting with requester 0.
   task automatic run_pair(input int n);
      int          idx[2];
      int          accepted, exp_owner, g;
      logic [31:0] a, b;
      logic [2:0]  sel;
      logic [63:0] res;
      idx[0] = 0; idx[1] = 0;
      accepted = 0; exp_owner = 0;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
         get_pair_op(p, 0, a, b, sel, res);
         load_port(p, a, b, sel);
      end
      req_valid = 2'b11;
      for (int t = 0; t < 300 && accepted < 2 * n; t++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            g = req_ready[1] ? 1 : 0;
            check("grant_order", 160'(g), 160'(exp_owner));
            get_pair_op(g, idx[g], a, b, sel, res);
            push_exp(g, res, 2'b00, 3, sel);
            idx[g]++;
            accepted++;
            exp_owner = 1 - exp_owner;
            @(posedge clk); #1;
            if (idx[g] < n) begin
               get_pair_op(g, idx[g], a, b, sel, res);
               load_port(g, a, b, sel);
            end else begin
               req_valid[g] = 1'b0;
            end
         end
      end
      if (accepted < 2 * n) begin
         n_total++; n_bad++;
         $display("FAIL pair_accepts: only %0d of %0d accepted", accepted, 2 * n);
      end
      req_valid = 2'b00;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s0;
      bit seen;
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      req_sel0 = '0; req_sel1 = '0;

      repeat (2) @(negedge clk);
      check("reset_outputs",
            160'({req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_sel, alu_start}),
            160'(0));
      check("reset_state", 160'(dbg_state), 160'(2'd0));
      check("reset_ptr", 160'(dbg_ptr), 160'(1'b0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Round-robin alternation straight out of reset.
      alu_delay = 1;
      run_pair(2);
      wait_drain();

      // Single ADD, ALU answers in the first WAIT cycle.
      send(0, 32'd5, 32'd7, 3'd0, 64'd12, 2'b00, 3);
      wait_drain();

      // ALU answers in WAIT cycle 3.
      alu_delay = 3;
      send(1, 32'd20, 32'd22, 3'd0, 64'd42, 2'b00, 5);
      wait_drain();
      alu_delay = 1;

      // Illegal opcode never starts the ALU.
      s0 = start_cnt;
      send(1, 32'd11, 32'd22, 3'd7, 64'd0, 2'b10, 2);
      wait_drain();
      check("illegal_no_start", 160'(start_cnt), 160'(s0));

      // DIV that never completes, a stale valid afterwards, then a normal op.
      alu_delay = 0;
      send(0, 32'd100, 32'd5, 3'd3, 64'd0, 2'b11, TMO + 3);
      wait_drain();
      stale_req++;
      repeat (4) @(negedge clk);
      check("idle_after_stale", 160'(dbg_state), 160'(2'd0));
      alu_delay = 1;
      send(1, 32'd1, 32'd2, 3'd0, 64'd3, 2'b00, 3);
      wait_drain();

      // Overflowing MUL held for 5 cycles; the non-owner's ready must not complete it.
      rsp_ready = 2'b10;
      alu_ovf_cfg = 1'b1;
      send(0, 32'hFFFF_FFFF, 32'd3, 3'd2, 64'h2_FFFF_FFFD, 2'b01, 3);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = (rsp_valid != 2'b00);
      end
      check("ovf_rsp_seen", 160'(seen), 160'(1'b1));
      repeat (5) @(posedge clk);
      #1;
      check("ovf_still_resp", 160'(dbg_state), 160'(2'd3));
      rsp_ready = 2'b11;
      alu_ovf_cfg = 1'b0;
      wait_drain();

      // Reset while the ALU is busy abandons the operation.
      alu_delay = 0;
      send(0, 32'd3, 32'd4, 3'd0, 64'd7, 2'b00, 3);
      repeat (2) @(negedge clk);
      check("wait_before_reset", 160'(dbg_state), 160'(2'd2));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs",
            160'({req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_sel, alu_start}),
            160'(0));
      check("midreset_state", 160'(dbg_state), 160'(2'd0));
      check("midreset_ptr", 160'(dbg_ptr), 160'(1'b0));
      exp_q.delete();
      exp_cyc_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      alu_delay = 1;
      run_pair(1);
      wait_drain();

      check("alu_start_count", 160'(start_cnt), 160'(legal_cnt));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #100000;
      n_total++; n_bad++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
